// File: rtl/ibex_if_id_dummy_stage_pkg.sv
// Shared constants and helpers for the IF/ID stage that merges real and dummy instructions.
// Dummy instructions must never write a register, so their rd field is cleared.
package ibex_if_id_dummy_stage_pkg;

  localparam logic [6:0] OPCODE_OP = 7'h33;
  localparam int         RD_MSB    = 11;
  localparam int         RD_LSB    = 7;

  // Force rd to x0 so a dummy instruction has no architectural side effect.
  function automatic logic [31:0] clearRd(input logic [31:0] instr);
    logic [31:0] result;
    result                = instr;
    result[RD_MSB:RD_LSB] = '0;
    return result;
  endfunction

endpackage

// File: rtl/ibex_if_id_dummy_stage_if.sv
// Fetch-side and ID-side signals of the IF/ID stage grouped into one bundle.
// The slave modport is the stage itself; the master modport is its surroundings.
interface ibex_if_id_dummy_stage_if;
  import ibex_if_id_dummy_stage_pkg::*;

  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_err_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        id_ready_i;
  logic        instr_valid_id_o;
  logic [31:0] instr_rdata_id_o;
  logic [31:0] instr_addr_id_o;
  logic        instr_fetch_err_o;
  logic        instr_is_dummy_o;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i, flush_i, id_ready_i,
    output fetch_ready_o, instr_valid_id_o, instr_rdata_id_o, instr_addr_id_o,
           instr_fetch_err_o, instr_is_dummy_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i, flush_i, id_ready_i,
    input  fetch_ready_o, instr_valid_id_o, instr_rdata_id_o, instr_addr_id_o,
           instr_fetch_err_o, instr_is_dummy_o
  );

endinterface

// File: rtl/ibex_if_id_dummy_stage.sv
// IF->ID pipeline register that interleaves dummy instructions with real fetches,
// holding the fetched instruction back while a dummy occupies the ID slot.
module ibex_if_id_dummy_stage
  import ibex_if_id_dummy_stage_pkg::*;
#(
  parameter bit DummyInstrEn = 1'b1,
  parameter int CntW         = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ibex_if_id_dummy_stage_if.slave   bus,
  input  logic                      insert_dummy_instr_i,
  input  logic [31:0]               dummy_instr_data_i,
  output logic                      fetch_valid_o,
  output logic                      id_in_ready_o,
  output logic [CntW-1:0]           dummy_cnt_o
);

  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  logic            r_valid;
  logic [31:0]     r_rdata;
  logic [31:0]     r_addr;
  logic            r_err;
  logic            r_isDummy;
  logic [CntW-1:0] r_dummyCnt;

  logic            w_idInReady;
  logic            w_dummyLoad;
  logic            w_fetchLoad;

  // A dummy wins over a pending fetch; flush suppresses both through w_idInReady.
  always_comb begin
    w_idInReady = 1'b0;
    w_dummyLoad = 1'b0;
    w_fetchLoad = 1'b0;
    w_idInReady = ~bus.flush_i & (~r_valid | bus.id_ready_i);
    w_dummyLoad = DummyInstrEn & insert_dummy_instr_i & w_idInReady;
    w_fetchLoad = bus.fetch_valid_i & w_idInReady & ~w_dummyLoad;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_isDummy  <= 1'b0;
      r_dummyCnt <= '0;
    end else if (bus.flush_i) begin
      r_valid   <= 1'b0;
      r_isDummy <= 1'b0;
    end else if (w_dummyLoad) begin
      r_valid   <= 1'b1;
      r_isDummy <= 1'b1;
      r_rdata   <= clearRd(dummy_instr_data_i);
      r_err     <= 1'b0;
      if (bus.fetch_valid_i) begin
        r_addr <= bus.fetch_addr_i;
      end
      if (r_dummyCnt != CntMax) begin
        r_dummyCnt <= r_dummyCnt + CntOne;
      end
    end else if (w_fetchLoad) begin
      r_valid   <= 1'b1;
      r_isDummy <= 1'b0;
      r_rdata   <= bus.fetch_rdata_i;
      r_addr    <= bus.fetch_addr_i;
      r_err     <= bus.fetch_err_i;
    end else if (bus.id_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.fetch_ready_o     = w_fetchLoad;
  assign bus.instr_valid_id_o  = r_valid;
  assign bus.instr_rdata_id_o  = r_rdata;
  assign bus.instr_addr_id_o   = r_addr;
  assign bus.instr_fetch_err_o = r_err;
  assign bus.instr_is_dummy_o  = r_isDummy;
  assign fetch_valid_o         = bus.fetch_valid_i & ~bus.flush_i;
  assign id_in_ready_o         = w_idInReady;
  assign dummy_cnt_o           = r_dummyCnt;

endmodule
